// File: rtl/shiftadd_seq_ctrl.sv
// shiftadd_seq_ctrl
// Sequential shift-add modular reducer. A request carries an operand and a
// modulus. The modulus is classified as Mersenne (2^k-1) or Fermat-like
// (2^(k-1)+1). The operand is then folded one b-bit chunk per cycle into an
// accumulator that is kept in [0, m). Unsupported moduli return err with a
// zero result.

module shiftadd_seq_ctrl #(
    parameter int DATA_LENGTH = 64,
    parameter int MAX_BL      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] x_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   err_o,
    output logic                   busy_o
);

    // Shift amounts never exceed MAX_BL, but this width covers any DATA_LENGTH shift.
    localparam int SHW = $clog2(DATA_LENGTH) + 1;

    localparam logic [DATA_LENGTH-1:0] ONE   = DATA_LENGTH'(1);
    localparam logic [DATA_LENGTH-1:0] ZERO  = {DATA_LENGTH{1'b0}};
    localparam logic [DATA_LENGTH-1:0] K_MIN_MERS = DATA_LENGTH'(2);
    localparam logic [DATA_LENGTH-1:0] K_MAX_MERS = DATA_LENGTH'(MAX_BL);
    localparam logic [DATA_LENGTH-1:0] K_MIN_FERM = DATA_LENGTH'(3);
    localparam logic [DATA_LENGTH-1:0] K_MAX_FERM = DATA_LENGTH'(MAX_BL + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_FOLD     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                 state_r, state_s;

    // Working registers: r_r holds the not-yet-folded remainder of x.
    logic [DATA_LENGTH-1:0] r_r,    r_s;
    logic [DATA_LENGTH-1:0] m_r,    m_s;
    logic [DATA_LENGTH-1:0] m_bl_r, m_bl_s;
    logic [DATA_LENGTH-1:0] acc_r,  acc_s;
    logic [SHW-1:0]         b_r,    b_s;
    logic                   alt_r,  alt_s;
    logic                   neg_r,  neg_s;
    logic                   err_r,  err_s;

    // Output registers, loaded from the next-state values.
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [DATA_LENGTH-1:0] result_r, result_s;
    logic                   err_out_r;
    logic                   busy_r;

    // Classification results.
    logic [DATA_LENGTH-1:0] mers_val_s;
    logic [DATA_LENGTH-1:0] ferm_val_s;
    logic                   is_mers_s;
    logic                   is_ferm_s;

    // Fold datapath.
    logic [DATA_LENGTH-1:0] mask_s;
    logic [DATA_LENGTH-1:0] chunk_s;
    logic [DATA_LENGTH:0]   sum_s;
    logic [DATA_LENGTH:0]   diff_s;
    logic [DATA_LENGTH-1:0] fold_acc_s;
    logic [DATA_LENGTH-1:0] r_shift_s;
    logic                   last_chunk_s;

    // Low-b-bit mask; b is at most MAX_BL so the shift never reaches the width.
    function automatic logic [DATA_LENGTH-1:0] low_mask(input logic [SHW-1:0] nbits);
        low_mask = (ONE << nbits) - ONE;
    endfunction

    // Compare the captured modulus against the two supported shapes for k = m_bl.
    always_comb begin
        mers_val_s = low_mask(m_bl_r[SHW-1:0]);
        ferm_val_s = (ONE << (m_bl_r[SHW-1:0] - SHW'(1))) + ONE;
        is_mers_s  = (m_bl_r >= K_MIN_MERS) && (m_bl_r <= K_MAX_MERS) && (m_r == mers_val_s);
        is_ferm_s  = (m_bl_r >= K_MIN_FERM) && (m_bl_r <= K_MAX_FERM) && (m_r == ferm_val_s);
    end

    // One fold step: add or subtract the current chunk and keep acc in [0, m).
    always_comb begin
        mask_s    = low_mask(b_r);
        chunk_s   = r_r & mask_s;
        sum_s     = {1'b0, acc_r} + {1'b0, chunk_s};
        diff_s    = {1'b0, acc_r} - {1'b0, chunk_s};
        r_shift_s = r_r >> b_r;
        last_chunk_s = (r_shift_s == ZERO);
        if (alt_r && neg_r) begin
            // Borrow means acc - c went negative; acc < m and c < m so one +m fixes it.
            if (diff_s[DATA_LENGTH]) begin
                fold_acc_s = diff_s[DATA_LENGTH-1:0] + m_r;
            end else begin
                fold_acc_s = diff_s[DATA_LENGTH-1:0];
            end
        end else begin
            // acc + c < 2m, so a single conditional subtract suffices.
            if (sum_s >= {1'b0, m_r}) begin
                fold_acc_s = sum_s[DATA_LENGTH-1:0] - m_r;
            end else begin
                fold_acc_s = sum_s[DATA_LENGTH-1:0];
            end
        end
    end

    // Next-state and next working-register values.
    always_comb begin
        state_s  = state_r;
        r_s      = r_r;
        m_s      = m_r;
        m_bl_s   = m_bl_r;
        acc_s    = acc_r;
        b_s      = b_r;
        alt_s    = alt_r;
        neg_s    = neg_r;
        err_s    = err_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) begin
                    r_s     = x_i;
                    m_s     = m_i;
                    m_bl_s  = m_bl_i;
                    err_s   = 1'b0;
                    state_s = ST_CLASSIFY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLASSIFY: begin
                acc_s = ZERO;
                neg_s = 1'b0;
                if (is_mers_s) begin
                    // Mersenne wins when both shapes match (m = 3).
                    b_s     = m_bl_r[SHW-1:0];
                    alt_s   = 1'b0;
                    err_s   = 1'b0;
                    state_s = ST_FOLD;
                end else if (is_ferm_s) begin
                    b_s     = m_bl_r[SHW-1:0] - SHW'(1);
                    alt_s   = 1'b1;
                    err_s   = 1'b0;
                    state_s = ST_FOLD;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                end
            end
            ST_FOLD: begin
                acc_s = fold_acc_s;
                r_s   = r_shift_s;
                if (alt_r) begin
                    neg_s = ~neg_r;
                end else begin
                    neg_s = neg_r;
                end
                if (last_chunk_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FOLD;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Result presented in DONE; forced to zero on the error path and outside DONE.
    always_comb begin
        if (state_s == ST_DONE) begin
            if (err_s) begin
                result_s = ZERO;
            end else begin
                result_s = acc_s;
            end
        end else begin
            result_s = ZERO;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Working registers for the operand, modulus and accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r    <= ZERO;
            m_r    <= ZERO;
            m_bl_r <= ZERO;
            acc_r  <= ZERO;
            b_r    <= {SHW{1'b0}};
            alt_r  <= 1'b0;
            neg_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            r_r    <= r_s;
            m_r    <= m_s;
            m_bl_r <= m_bl_s;
            acc_r  <= acc_s;
            b_r    <= b_s;
            alt_r  <= alt_s;
            neg_r  <= neg_s;
            err_r  <= err_s;
        end
    end

    // Output registers decoded from the upcoming state so they align with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= ZERO;
            err_out_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            result_r    <= result_s;
            err_out_r   <= (state_s == ST_DONE) && err_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign result_o    = result_r;
    assign err_o       = err_out_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_shiftadd_seq_ctrl.sv
// Directed self-checking bench for shiftadd_seq_ctrl.
`timescale 1ns/1ps

module tb_shiftadd_seq_ctrl;

    localparam int DL = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DL-1:0] x_i = '0;
    logic [DL-1:0] m_i = '0;
    logic [DL-1:0] m_bl_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DL-1:0] result_o;
    logic          err_o;
    logic          busy_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    shiftadd_seq_ctrl #(.DATA_LENGTH(64), .MAX_BL(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .m_i         (m_i),
        .m_bl_i      (m_bl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Issue one request, measure latency (edges after accept), check result,
    // optionally stall the consumer for hold cycles, then complete the handshake.
    task automatic run_req(input string tag, input logic [DL-1:0] x, input logic [DL-1:0] m,
                           input logic [DL-1:0] bl, input logic [DL-1:0] exp_res,
                           input logic exp_err, input int exp_lat, input int hold);
        int lat;
        int w;
        logic [DL-1:0] res_hold;
        @(negedge clk_i);
        w = 0;
        while (!in_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        check_val({tag, ".ready"}, {63'd0, in_ready_o}, 64'd1);
        x_i = x; m_i = m; m_bl_i = bl; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        x_i = '0; m_i = '0; m_bl_i = '0;
        check_val({tag, ".busy"}, {63'd0, busy_o}, 64'd1);
        lat = 0;
        while (lat < 64) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (out_valid_o) break;
        end
        check_val({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, ".res"}, result_o, exp_res);
        check_val({tag, ".err"}, {63'd0, err_o}, {63'd0, exp_err});
        res_hold = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            check_val({tag, ".stall_valid"}, {63'd0, out_valid_o}, 64'd1);
            check_val({tag, ".stall_res"}, result_o, res_hold);
            check_val({tag, ".stall_err"}, {63'd0, err_o}, {63'd0, exp_err});
            check_val({tag, ".stall_rdy"}, {63'd0, in_ready_o}, 64'd0);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check_val({tag, ".idle_rdy"}, {63'd0, in_ready_o}, 64'd1);
        check_val({tag, ".idle_vld"}, {63'd0, out_valid_o}, 64'd0);
    endtask

    initial begin : main
        int pulse;
        #12;
        // Reset values while reset is held.
        check_val("rst.ready", {63'd0, in_ready_o}, 64'd1);
        check_val("rst.valid", {63'd0, out_valid_o}, 64'd0);
        check_val("rst.result", result_o, 64'd0);
        check_val("rst.err", {63'd0, err_o}, 64'd0);
        check_val("rst.busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Mersenne m=7: chunks 4,4,1 -> acc 4,1,2; n=3.
        run_req("mers7", 64'd100, 64'd7, 64'd3, 64'd2, 1'b0, 4, 0);
        // Fermat m=17: chunks +8,-14,+3 -> acc 8,11,14; n=3.
        run_req("ferm17", 64'd1000, 64'd17, 64'd5, 64'd14, 1'b0, 4, 0);
        // m=2^32-1, x=2^64-1: two chunks equal to m -> 0; n=2.
        run_req("mers32", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd32, 64'd0, 1'b0, 3, 0);
        // m=2^32+1, x=2^64-1: +(2^32-1) then -(2^32-1) -> 0; n=2.
        run_req("ferm33", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001, 64'd33, 64'd0, 1'b0, 3, 0);
        // x=0 still takes one fold cycle.
        run_req("x0", 64'd0, 64'd7, 64'd3, 64'd0, 1'b0, 2, 0);
        // m=3 with k=2 is Mersenne: 10 mod 3 = 1; chunks 2,2 -> acc 2,1; n=2.
        run_req("mers3", 64'd10, 64'd3, 64'd2, 64'd1, 1'b0, 3, 0);
        // Unsupported moduli.
        run_req("bad10", 64'd55, 64'd10, 64'd4, 64'd0, 1'b1, 1, 0);
        run_req("bad40", 64'd55, 64'h0000_00FF_FFFF_FFFF, 64'd40, 64'd0, 1'b1, 1, 0);
        // Backpressure then a back-to-back request; 1000 mod 7 = 6.
        run_req("stall", 64'd100, 64'd7, 64'd3, 64'd2, 1'b0, 4, 5);
        run_req("b2b", 64'd1000, 64'd7, 64'd3, 64'd6, 1'b0, 5, 0);

        // Reset during the second fold cycle of the m=7, x=100 case.
        @(negedge clk_i);
        x_i = 64'd100; m_i = 64'd7; m_bl_i = 64'd3; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("arst.ready", {63'd0, in_ready_o}, 64'd1);
        check_val("arst.valid", {63'd0, out_valid_o}, 64'd0);
        check_val("arst.busy", {63'd0, busy_o}, 64'd0);
        check_val("arst.result", result_o, 64'd0);
        pulse = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (out_valid_o) pulse++;
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (out_valid_o || busy_o) pulse++;
        end
        check_val("arst.no_pulse", 64'(pulse), 64'd0);
        run_req("after_rst", 64'd100, 64'd7, 64'd3, 64'd2, 1'b0, 4, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shiftadd_seq_ctrl.md
# shiftadd_seq_ctrl

Sequential controller for shift-add modular reduction. It accepts one operand/modulus pair through a valid/ready handshake and classifies the modulus as Mersenne (2^k−1) or Fermat-like (2^(k−1)+1). It then folds the operand one chunk per cycle into a bounded accumulator and returns the residue through a second valid/ready handshake. It replaces the fully combinational fold chain wherever the reduction is shared and variable-length operands must be handled correctly.

## Interface
- DATA_LENGTH, 64, operand/modulus/result width
- MAX_BL, 32, largest supported modulus bit length
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  request valid
- in_ready_o  out  1  controller can accept a request
- x_i  in  DATA_LENGTH  operand
- m_i  in  DATA_LENGTH  modulus
- m_bl_i  in  DATA_LENGTH  bit length k of m_i
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  DATA_LENGTH  x mod m
- err_o  out  1  modulus unsupported (qualified by out_valid_o)
- busy_o  out  1  controller not in IDLE

## Operation
- States: IDLE, CLASSIFY, FOLD, DONE.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, register x_i, m_i, m_bl_i, then go to CLASSIFY.
- CLASSIFY (1 cycle): k=m_bl.
  - Mersenne if 2≤k≤MAX_BL and m==2^k−1. Sets b=k, mode=ADD.
  - Else Fermat if 3≤k≤MAX_BL+1 and m==2^(k−1)+1. Sets b=k−1, mode=ALT.
  - Mersenne takes priority (m=3).
  - Otherwise err=1 and the next state is DONE with result 0.
  - On success: acc=0, r=x, sign=+, next state is FOLD.
- FOLD (1 chunk/cycle):
  - c = r & (2^b−1).
  - ADD: t=acc+c; if t≥m then acc=t−m else acc=t.
  - ALT with sign=+: same as ADD.
  - ALT with sign=−: t=acc−c, signed with DATA_LENGTH+1 bits; if t<0 then acc=t+m else acc=t.
  - Then r=r>>b, and sign toggles in ALT mode only.
  - Exit to DONE when (r>>b)==0, i.e. the processed chunk was the last nonzero one. x=0 still takes one FOLD cycle.
- Invariant: 0≤acc<m after every FOLD cycle. No final correction is needed.
- Chunk count n = max(1, ceil(bitlen(x)/b)), 1..32.
- DONE: out_valid_o=1; result_o=acc (0 if err); err_o valid. On out_ready_i, go to IDLE. Outputs stay stable while stalled.
- in_ready_o=0 in every state except IDLE. There is no request overlap.

## Timing
- Reset (async assert, sync deassert assumed at top level):
  - state=IDLE; in_ready_o=1.
  - out_valid_o=0, result_o=0, err_o=0, busy_o=0.
  - All internal registers are cleared.
- Accept at edge t:
  - CLASSIFY during cycle t+1.
  - FOLD during cycles t+2 .. t+1+n.
  - out_valid_o=1 from t+2+n.
- Error path: out_valid_o=1 from t+2.
- Handshake completes on the edge where out_valid_o&&out_ready_i. IDLE (in_ready_o=1) follows in the next cycle.
- Minimum request spacing is n+3 cycles.
- Reset asserted in any state aborts immediately. No result is emitted and the partial acc is discarded.
- in_valid_i while busy is ignored (ready low). The requester must hold its inputs.
- out_ready_i high before out_valid_o has no effect.

## Test plan
- Mersenne: m=7, m_bl=3, x=100.
  - Chunks 4, 4, 1; acc 4→1→2.
  - Expect result_o=2, err_o=0, out_valid_o at t+5.
- Fermat: m=17, m_bl=5, x=1000.
  - Chunks +8, −14, +3; acc 8→11→14.
  - Expect result_o=14, out_valid_o at t+5.
- Boundaries:
  - m=2^32−1, m_bl=32, x=2^64−1: two chunks equal to m; expect result_o=0 at t+4.
  - x=0, m=7: expect result_o=0 at t+3.
- Unsupported modulus:
  - m=10, m_bl=4: expect err_o=1, result_o=0 at t+2.
  - m_bl=40: expect err_o=1.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE.
  - result_o, err_o and out_valid_o stay stable; in_ready_o=0.
  - Release out_ready_i; in_ready_o=1 on the next cycle; a back-to-back second request is accepted.
- Reset mid-FOLD: assert rst_ni=0 during the second FOLD cycle of the m=7, x=100 case.
  - All outputs go to reset values at once and no out_valid_o pulse appears.
  - A new request after reset gives the correct result.
